// File: rtl/double_mul_arbiter_pkg.sv
// Shared widths, default multiplier latency and the double-precision multiply
// function used by the pipelined double_mul.
package double_mul_arbiter_pkg;

  localparam int DOUBLE_WIDTH       = 64;
  localparam int ID_WIDTH           = 1;
  localparam int DOUBLE_MUL_LATENCY = 6;

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [DOUBLE_WIDTH-1:0] product;
  } result_t;

  // IEEE-754 binary64 multiply, round-to-nearest-even; subnormals flush to zero.
  function automatic logic [DOUBLE_WIDTH-1:0] fp_mul(input logic [DOUBLE_WIDTH-1:0] a,
                                                     input logic [DOUBLE_WIDTH-1:0] b);
    logic               sign;
    logic [10:0]        ea;
    logic [10:0]        eb;
    logic [51:0]        fa;
    logic [51:0]        fb;
    logic               a_nan;
    logic               b_nan;
    logic               a_inf;
    logic               b_inf;
    logic               a_zero;
    logic               b_zero;
    logic [105:0]       prod;
    logic [51:0]        frac;
    logic               guard;
    logic               sticky;
    logic [52:0]        rnd;
    logic signed [13:0] e;
    logic [DOUBLE_WIDTH-1:0] res;
    sign   = a[63] ^ b[63];
    ea     = a[62:52];
    eb     = b[62:52];
    fa     = a[51:0];
    fb     = b[51:0];
    a_nan  = (ea == 11'h7FF) && (fa != '0);
    b_nan  = (eb == 11'h7FF) && (fb != '0);
    a_inf  = (ea == 11'h7FF) && (fa == '0);
    b_inf  = (eb == 11'h7FF) && (fb == '0);
    a_zero = (ea == 11'h000);
    b_zero = (eb == 11'h000);
    prod   = 106'({1'b1, fa}) * 106'({1'b1, fb});
    e      = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 14'sd1023;
    if (prod[105]) begin
      frac   = prod[104:53];
      guard  = prod[52];
      sticky = |prod[51:0];
      e      = e + 14'sd1;
    end else begin
      frac   = prod[103:52];
      guard  = prod[51];
      sticky = |prod[50:0];
    end
    rnd = {1'b0, frac} + {52'b0, guard & (sticky | frac[0])};
    if (rnd[52]) e = e + 14'sd1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      res = 64'h7FF8_0000_0000_0000;
    else if (a_inf || b_inf || (e >= 14'sd2047))
      res = {sign, 11'h7FF, 52'b0};
    else if (a_zero || b_zero || (e <= 14'sd0))
      res = {sign, 63'b0};
    else
      res = {sign, e[10:0], rnd[51:0]};
    return res;
  endfunction

endpackage

// File: rtl/double_mul.sv
// Fixed-latency pipelined double multiplier: operands sampled on one edge,
// product on z after LATENCY edges counting the sampling edge. Never stalls.
module double_mul
  import double_mul_arbiter_pkg::*;
#(
  parameter int LATENCY = DOUBLE_MUL_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DOUBLE_WIDTH-1:0] a,
  input  logic [DOUBLE_WIDTH-1:0] b,
  output logic [DOUBLE_WIDTH-1:0] z
);

  logic [DOUBLE_WIDTH-1:0] a_q;
  logic [DOUBLE_WIDTH-1:0] b_q;
  logic [DOUBLE_WIDTH-1:0] z_pipe [LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < LATENCY - 1; i++) z_pipe[i] <= '0;
    end else begin
      a_q       <= a;
      b_q       <= b;
      z_pipe[0] <= fp_mul(a_q, b_q);
      for (int i = 1; i < LATENCY - 1; i++) z_pipe[i] <= z_pipe[i-1];
    end
  end

  assign z = z_pipe[LATENCY-2];

endmodule

// File: rtl/double_mul_result_fifo.sv
// Result FIFO holding {id, product}; count is exported for the issue credit check.
module double_mul_result_fifo
  import double_mul_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  result_t                    push_data,
  input  logic                       pop,
  output result_t                    head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  result_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      unique case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; the top gates the head with empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // The issue credit must make an overflowing push impossible.
  always @(posedge clk) begin
    if (!rst) assert (!(push && full));
  end

endmodule

// File: rtl/double_mul_arbiter.sv
// Two-port round-robin front end sharing one double_mul; results are id-tagged
// and returned in issue order through a credit-protected result FIFO.
module double_mul_arbiter
  import double_mul_arbiter_pkg::*;
#(
  parameter int LATENCY    = DOUBLE_MUL_LATENCY,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DOUBLE_WIDTH-1:0] in0_a,
  input  logic [DOUBLE_WIDTH-1:0] in0_b,
  input  logic                    in0_stb,
  output logic                    in0_ack,
  input  logic [DOUBLE_WIDTH-1:0] in1_a,
  input  logic [DOUBLE_WIDTH-1:0] in1_b,
  input  logic                    in1_stb,
  output logic                    in1_ack,
  output logic [DOUBLE_WIDTH-1:0] z,
  output logic [ID_WIDTH-1:0]     z_id,
  output logic                    z_stb,
  input  logic                    z_ack,
  output logic                    busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(LATENCY + 1);

  logic [ID_WIDTH-1:0]     ptr;
  logic [ID_WIDTH-1:0]     grant_id;
  logic                    issue;
  logic                    credit_ok;
  int                      credit_used;
  logic [DOUBLE_WIDTH-1:0] op_a_q;
  logic [DOUBLE_WIDTH-1:0] op_b_q;
  logic [DOUBLE_WIDTH-1:0] mul_a;
  logic [DOUBLE_WIDTH-1:0] mul_b;
  logic [DOUBLE_WIDTH-1:0] mul_z;
  logic [LATENCY-1:0]      tag_valid;
  logic [ID_WIDTH-1:0]     tag_id [LATENCY];
  logic [INF_W-1:0]        inflight_count;
  logic                    capture;
  result_t                 fifo_head;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;

  // Pops in the current cycle are deliberately not credited.
  assign credit_used = int'(fifo_count) + int'(inflight_count);
  assign credit_ok   = !fifo_full && (credit_used < FIFO_DEPTH);

  always_comb begin
    grant_id = '0;
    if (in0_stb && in1_stb) grant_id = ptr;
    else if (in1_stb)       grant_id = ID_WIDTH'(1);
    issue   = credit_ok && (in0_stb || in1_stb);
    in0_ack = issue && (grant_id == '0);
    in1_ack = issue && (grant_id != '0);
    mul_a   = op_a_q;
    mul_b   = op_b_q;
    if (issue) begin
      mul_a = (grant_id == '0) ? in0_a : in1_a;
      mul_b = (grant_id == '0) ? in0_b : in1_b;
    end
  end

  assign capture = tag_valid[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      tag_valid      <= '0;
      inflight_count <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      if (issue) begin
        ptr    <= ~grant_id;
        op_a_q <= mul_a;
        op_b_q <= mul_b;
      end
      tag_valid[0] <= issue;
      tag_id[0]    <= grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      unique case ({issue, capture})
        2'b10:   inflight_count <= inflight_count + INF_W'(1);
        2'b01:   inflight_count <= inflight_count - INF_W'(1);
        default: ;
      endcase
    end
  end

  double_mul #(
    .LATENCY(LATENCY)
  ) u_mul (
    .clk(clk),
    .rst(rst),
    .a  (mul_a),
    .b  (mul_b),
    .z  (mul_z)
  );

  assign pop = z_stb && z_ack;

  double_mul_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (capture),
    .push_data('{id: tag_id[LATENCY-1], product: mul_z}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign z_stb = !fifo_empty;
  assign z     = fifo_empty ? '0 : fifo_head.product;
  assign z_id  = fifo_empty ? '0 : fifo_head.id;
  assign busy  = (inflight_count != '0) || !fifo_empty;

endmodule

// File: tb/tb_double_mul_arbiter.sv
// Bench for double_mul_arbiter: a queue-based model of outstanding results with
// products computed in real arithmetic, compared cycle by cycle.
module tb_double_mul_arbiter;
  import double_mul_arbiter_pkg::*;

  localparam int LAT   = DOUBLE_MUL_LATENCY;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in0_a = '0, in0_b = '0, in1_a = '0, in1_b = '0;
  logic        in0_stb = 1'b0, in1_stb = 1'b0, z_ack = 1'b0;
  logic        in0_ack, in1_ack, z_stb, busy;
  logic [63:0] z;
  logic [0:0]  z_id;

  double_mul_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in0_a(in0_a), .in0_b(in0_b), .in0_stb(in0_stb), .in0_ack(in0_ack),
    .in1_a(in1_a), .in1_b(in1_b), .in1_stb(in1_stb), .in1_ack(in1_ack),
    .z(z), .z_id(z_id), .z_stb(z_stb), .z_ack(z_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [63:0] prod;
    int          ready;
  } res_t;

  res_t        q[$];
  logic        ptr_m = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        exp_issue;
  logic        exp_gid;
  logic [68:0] exp_vec;

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_dbl();
    return {1'($urandom_range(0, 1)), 11'(823 + $urandom_range(0, 400)), 20'($urandom), $urandom};
  endfunction

  function automatic logic [68:0] obs();
    return {in0_ack, in1_ack, z_stb, z_id, busy, z};
  endfunction

  // Expected {ack0, ack1, z_stb, z_id, busy, z} for the current cycle.
  task automatic model_eval();
    logic zs;
    exp_gid   = (in0_stb && in1_stb) ? ptr_m : in1_stb;
    exp_issue = (q.size() < DEPTH) && (in0_stb || in1_stb);
    zs        = 1'b0;
    if (q.size() > 0) zs = (q[0].ready <= cyc);
    exp_vec   = {exp_issue && !exp_gid, exp_issue && exp_gid, zs, 1'b0, q.size() > 0, 64'h0};
    if (zs) begin
      exp_vec[65]   = q[0].id;
      exp_vec[63:0] = q[0].prod;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (exp_vec[66] && z_ack) void'(q.pop_front());
    if (exp_issue) begin
      q.push_back('{exp_gid, ref_mul(exp_gid ? in1_a : in0_a, exp_gid ? in1_b : in0_b), cyc + 1 + LAT});
      ptr_m = ~exp_gid;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs() !== 69'h0) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected 0", obs());
    end
    rst = 1'b0;
    @(posedge clk); #1;
    q.delete();
    ptr_m = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model_eval(); @(negedge clk); n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: got %h expected %h", cyc, obs(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_single();
    z_ack = 1'b1;
    in0_a = 64'h4000_0000_0000_0000;
    in0_b = 64'h4008_0000_0000_0000;
    for (int k = 0; k <= LAT + 3; k++) begin
      in0_stb = (k == 0);
      model_eval(); @(negedge clk); n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL single c%0d: got %h expected %h", cyc, obs(), exp_vec);
      end
      if (k == LAT + 1) begin
        n_cmp++;
        if ({z_stb, z_id, z} !== {1'b1, 1'b0, 64'h4018_0000_0000_0000}) begin
          n_fail++;
          $display("FAIL single_product: got stb=%b id=%b z=%h expected stb=1 id=0 z=4018000000000000", z_stb, z_id, z);
        end
      end
      advance();
    end
  endtask

  task automatic test_alternate();
    z_ack = 1'b1;
    in0_a = 64'h3FF8_0000_0000_0000; in0_b = 64'h4000_0000_0000_0000;
    in1_a = 64'hC000_0000_0000_0000; in1_b = 64'h4000_0000_0000_0000;
    for (int k = 0; k < 8 + LAT + 4; k++) begin
      in0_stb = (k < 8);
      in1_stb = (k < 8);
      model_eval(); @(negedge clk); n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL alternate c%0d: got %h expected %h", cyc, obs(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int acks = 0;
    z_ack   = 1'b0;
    in0_stb = 1'b1;
    in1_stb = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 20) z_ack = 1'b1;
      if (k == 40) in0_stb = 1'b0;
      in0_a = rand_dbl(); in0_b = rand_dbl();
      model_eval(); @(negedge clk); n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL backpressure c%0d: got %h expected %h", cyc, obs(), exp_vec);
      end
      if (k < 20 && in0_ack) acks++;
      if (k == 19) begin
        n_cmp++;
        if (acks != DEPTH) begin
          n_fail++;
          $display("FAIL backpressure_acks: got %0d expected %0d", acks, DEPTH);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    int   requested = 0;
    int   issued = 0;
    int   budget = 0;
    logic p0 = 1'b0, p1 = 1'b0;
    while (budget < 800 && (issued < 20 || q.size() > 0)) begin
      if (!p0 && requested < 20 && $urandom_range(0, 1) == 1) begin
        p0 = 1'b1; requested++; in0_a = rand_dbl(); in0_b = rand_dbl();
      end
      if (!p1 && requested < 20 && $urandom_range(0, 1) == 1) begin
        p1 = 1'b1; requested++; in1_a = rand_dbl(); in1_b = rand_dbl();
      end
      in0_stb = p0;
      in1_stb = p1;
      z_ack   = ($urandom_range(0, 2) != 0);
      model_eval(); @(negedge clk); n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL random c%0d: got %h expected %h", cyc, obs(), exp_vec);
      end
      advance();
      if (exp_issue) begin
        if (exp_gid) p1 = 1'b0;
        else         p0 = 1'b0;
        issued++;
      end
      budget++;
    end
    in0_stb = 1'b0; in1_stb = 1'b0; z_ack = 1'b1;
    n_cmp++;
    if (issued != 20 || q.size() != 0) begin
      n_fail++;
      $display("FAIL random_timeout: issued %0d pending %0d expected 20 and 0", issued, q.size());
    end
  endtask

  task automatic test_reset_mid();
    z_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in0_stb = (k < 3);
      in0_a = rand_dbl(); in0_b = rand_dbl();
      model_eval(); @(negedge clk); n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_mid_pre c%0d: got %h expected %h", cyc, obs(), exp_vec);
      end
      advance();
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 69'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected 0", obs());
    end
    q.delete();
    ptr_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cyc++;
    in1_a = 64'h4000_0000_0000_0000;
    in1_b = 64'h4008_0000_0000_0000;
    for (int k = 0; k < 2 * LAT + 6; k++) begin
      in1_stb = (k == LAT + 2);
      model_eval(); @(negedge clk); n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_mid_post c%0d: got %h expected %h", cyc, obs(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_priority();
    z_ack   = 1'b1;
    in0_stb = 1'b0;
    for (int k = 0; k < 5 + LAT + 4; k++) begin
      in1_stb = (k < 5);
      in0_stb = (k == 4);
      in0_a = rand_dbl(); in0_b = rand_dbl();
      in1_a = rand_dbl(); in1_b = rand_dbl();
      model_eval(); @(negedge clk); n_cmp++;
      if (obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL priority c%0d: got %h expected %h", cyc, obs(), exp_vec);
      end
      if (k == 4) begin
        n_cmp++;
        if ({in0_ack, in1_ack} !== 2'b10) begin
          n_fail++;
          $display("FAIL priority_pointer: got acks %b expected 10", {in0_ack, in1_ack});
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
